// File: rtl/ipf_pkg.sv
// ipf_pkg: shared LCU size codes, filter type codes, parameter-word layout and geometry helpers.
package ipf_pkg;
  typedef enum logic [1:0] {LCU_16 = 2'd0, LCU_32 = 2'd1, LCU_64 = 2'd2, LCU_RSV = 2'd3} lcu_size_e;
  typedef enum logic [2:0] {S_IDLE, S_PRM_RD, S_PRM_LD, S_STREAM, S_WAIT_FIN, S_DONE} state_e;
  localparam logic [1:0] IPF_TYPE_OFF = 2'd0;
  localparam logic [1:0] IPF_TYPE_PO = 2'd1;
  localparam logic [1:0] IPF_TYPE_WO = 2'd2;
  localparam int PRM_TYPE_LSB = 22;
  localparam int PRM_BAND_LSB = 17;
  localparam int PRM_WO_BIT = 16;
  localparam int PRM_OFS_LSB = 0;
  function automatic logic [6:0] lcu_len(input logic [1:0] s);
    return 7'd16 << s;
  endfunction
  function automatic logic [3:0] lcu_cnt(input logic [1:0] s);
    return 4'd8 >> s;
  endfunction
endpackage

// File: rtl/ipf_skid_fifo.sv
// ipf_skid_fifo: 2-deep 8-bit buffer absorbing in-flight image reads while the filter is busy.
module ipf_skid_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       valid,
  output logic [1:0] count
);
  logic [7:0] mem [2];
  logic wp, rp;
  assign rdata = mem[rp];
  assign valid = count != 2'd0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '{default: '0};
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/ipf_lcu_streamer.sv
// ipf_lcu_streamer: streams a frame LCU by LCU from image RAM into the IPF filter,
// loading per-LCU filter parameters between LCUs and honouring busy back-pressure.
module ipf_lcu_streamer
  import ipf_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    cfg_lcu_size,
  output logic          img_rd,
  output logic [AW-1:0] img_addr,
  input  logic [7:0]    img_data,
  output logic          prm_rd,
  output logic [5:0]    prm_addr,
  input  logic [23:0]   prm_data,
  input  logic          busy,
  input  logic          finish,
  output logic          in_en,
  output logic [7:0]    din,
  output logic [1:0]    ipf_type,
  output logic [4:0]    ipf_band_pos,
  output logic          ipf_wo_class,
  output logic [15:0]   ipf_offset,
  output logic [2:0]    lcu_x,
  output logic [2:0]    lcu_y,
  output logic [1:0]    lcu_size,
  output logic          done
);
  state_e state, nxt;
  logic [6:0] r, c, ri, ci, lm1, row, col;
  logic [2:0] nm1;
  logic [1:0] buf_cnt;
  logic idone, pend, buf_valid, start_ok, pix_last, lcu_last;
  ipf_skid_fifo u_buf (
    .clk(clk), .reset(reset), .push(pend), .pop(in_en), .wdata(img_data),
    .rdata(din), .valid(buf_valid), .count(buf_cnt)
  );
  assign lm1 = lcu_len(lcu_size) - 7'd1;
  assign nm1 = 3'(lcu_cnt(lcu_size) - 4'd1);
  assign start_ok = start && cfg_lcu_size != LCU_RSV;
  assign in_en = buf_valid & ~busy & (state == S_STREAM);
  assign pix_last = in_en && r == lm1 && c == lm1;
  assign lcu_last = lcu_x == nm1 && lcu_y == nm1;
  // Occupancy plus the read in flight must leave room once this cycle's pop is counted.
  assign img_rd = state == S_STREAM && !idone &&
                  ({1'b0, buf_cnt} + {2'b0, pend} < 3'd2 + {2'b0, in_en});
  assign row = 7'({4'b0, lcu_y} << (3'd4 + {1'b0, lcu_size})) + ri;
  assign col = 7'({4'b0, lcu_x} << (3'd4 + {1'b0, lcu_size})) + ci;
  assign img_addr = img_rd ? AW'(row) * AW'(IMG_W) + AW'(col) : '0;
  assign prm_rd = state == S_PRM_RD;
  assign prm_addr = prm_rd ? 6'({3'b0, lcu_y} << (2'd3 - lcu_size)) | {3'b0, lcu_x} : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_DONE: nxt = start_ok ? S_PRM_RD : state;
      S_PRM_RD:       nxt = S_PRM_LD;
      S_PRM_LD:       nxt = S_STREAM;
      S_STREAM:       nxt = pix_last ? (lcu_last ? S_WAIT_FIN : S_PRM_RD) : state;
      S_WAIT_FIN:     nxt = finish ? S_DONE : state;
      default:        nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r, c, ri, ci} <= '0;
      {idone, pend, done} <= '0;
      {lcu_x, lcu_y, lcu_size} <= '0;
      {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset} <= '0;
    end else begin
      pend <= img_rd;
      if ((state == S_IDLE || state == S_DONE) && start_ok) begin
        lcu_size <= cfg_lcu_size;
        lcu_x <= 3'd0;
        lcu_y <= 3'd0;
        done <= 1'b0;
      end
      if (state == S_WAIT_FIN && finish) done <= 1'b1;
      if (state == S_PRM_LD) begin
        ipf_type <= prm_data[PRM_TYPE_LSB +: 2];
        ipf_band_pos <= prm_data[PRM_BAND_LSB +: 5];
        ipf_wo_class <= prm_data[PRM_WO_BIT];
        ipf_offset <= prm_data[PRM_OFS_LSB +: 16];
        {r, c, ri, ci} <= '0;
        idone <= 1'b0;
      end
      if (img_rd) begin
        ci <= ci == lm1 ? 7'd0 : ci + 7'd1;
        if (ci == lm1) ri <= ri + 7'd1;
        if (ci == lm1 && ri == lm1) idone <= 1'b1;
      end
      if (in_en) begin
        c <= c == lm1 ? 7'd0 : c + 7'd1;
        if (c == lm1) r <= r + 7'd1;
      end
      if (pix_last && !lcu_last) begin
        lcu_x <= lcu_x == nm1 ? 3'd0 : lcu_x + 3'd1;
        if (lcu_x == nm1) lcu_y <= lcu_y + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_ipf_lcu_streamer.sv
// tb_ipf_lcu_streamer: directed frames with random image/parameter data and busy patterns,
// checked against a pixel-order model built from the LCU geometry.
module tb_ipf_lcu_streamer;
  logic clk = 0, reset = 1, start = 0, busy = 0, finish = 0;
  logic [1:0] cfg_lcu_size = 0;
  logic img_rd, prm_rd, in_en, ipf_wo_class, done;
  logic [13:0] img_addr;
  logic [7:0] img_data = 0, din;
  logic [5:0] prm_addr;
  logic [23:0] prm_data = 0;
  logic [1:0] ipf_type, lcu_size;
  logic [4:0] ipf_band_pos;
  logic [15:0] ipf_offset;
  logic [2:0] lcu_x, lcu_y;
  int checks = 0, errors = 0;
  logic [7:0] img [16384];
  logic [23:0] prm [64];
  logic [7:0] din_log [16384];
  logic [7:0] ref_log [16384];
  logic [23:0] par_first;

  ipf_lcu_streamer dut (
    .clk(clk), .reset(reset), .start(start), .cfg_lcu_size(cfg_lcu_size),
    .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
    .prm_rd(prm_rd), .prm_addr(prm_addr), .prm_data(prm_data),
    .busy(busy), .finish(finish), .in_en(in_en), .din(din),
    .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos), .ipf_wo_class(ipf_wo_class),
    .ipf_offset(ipf_offset), .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (img_rd) img_data <= img[img_addr];
    if (prm_rd) prm_data <= prm[prm_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address of the i-th streamed pixel: LCUs in raster order, pixels in raster order inside each.
  function automatic int addr_of(input int s, input int i);
    int l, n, k, p;
    l = 16 << s;
    n = 8 >> s;
    k = i / (l * l);
    p = i % (l * l);
    return ((k / n) * l + p / l) * 128 + (k % n) * l + p % l;
  endfunction

  task automatic run_frame(input int s, input int bmode, input int max_pix, input int start_at, input int fin_at);
    int l, n, tot, lim, pix, rdn, prmn, bl, cyc, k;
    bit ssent, fsent;
    l = 16 << s;
    n = 8 >> s;
    tot = 16384;
    lim = max_pix < tot ? max_pix : tot;
    {pix, rdn, prmn, bl, cyc} = '0;
    {ssent, fsent} = '0;
    @(negedge clk);
    cfg_lcu_size = 2'(s);
    start = 1;
    @(negedge clk);
    start = 0;
    cfg_lcu_size = 2'($urandom);
    chk("done_clear", {31'b0, done}, 0);
    while (pix < lim && cyc < lim * 4 + 500) begin
      busy = bmode == 1 ? $urandom_range(0, 2) == 0 : bmode == 2 ? bl > 0 : 1'b0;
      if (bl > 0) bl--;
      start = start_at >= 0 && pix >= start_at && !ssent;
      if (start) begin
        ssent = 1;
        cfg_lcu_size = 2'($urandom);
      end
      finish = fin_at >= 0 && pix >= fin_at && !fsent;
      if (finish) fsent = 1;
      #1;
      if (busy) chk("busy_hold", {31'b0, in_en}, 0);
      if (prm_rd) begin
        chk("prm_addr", {26'b0, prm_addr}, prmn);
        prmn++;
      end
      if (img_rd) begin
        chk("img_addr", {18'b0, img_addr}, addr_of(s, rdn));
        rdn++;
      end
      if (in_en) begin
        k = pix / (l * l);
        chk("din", {24'b0, din}, {24'b0, img[addr_of(s, pix)]});
        chk("param", {8'b0, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}, {8'b0, prm[k]});
        chk("lcu_xy", {26'b0, lcu_y, lcu_x}, (k / n) * 8 + k % n);
        if (pix == 0) par_first = {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset};
        din_log[pix] = din;
        pix++;
        if (bmode == 2 && pix % 16 == 0) bl = 5;
      end
      cyc++;
      @(negedge clk);
    end
    {busy, start, finish} = '0;
    chk("pix_count", pix, lim);
    if (lim == tot) begin
      chk("lcu_count", prmn, n * n);
      chk("lcu_size", {30'b0, lcu_size}, s);
      repeat (3) begin
        #1;
        chk("wait_fin_idle", {29'b0, img_rd, in_en, done}, 0);
        @(negedge clk);
      end
      finish = 1;
      @(negedge clk);
      finish = 0;
      #1;
      chk("done_set", {31'b0, done}, 1);
    end
  endtask

  initial begin
    logic seen;
    int w, mism;
    for (int i = 0; i < 16384; i++) img[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) prm[i] = 24'($urandom);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctl", {img_rd, prm_rd, in_en, done, img_addr, prm_addr, lcu_x, lcu_y, lcu_size}, 0);
    chk("reset_dat", {din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}, 0);
    @(negedge clk);
    reset = 0;
    // Reserved LCU size: start must be ignored.
    @(negedge clk);
    cfg_lcu_size = 2'd3;
    start = 1;
    @(negedge clk);
    start = 0;
    seen = 0;
    repeat (4) begin
      #1;
      seen |= prm_rd | img_rd | in_en;
      @(negedge clk);
    end
    chk("rsv_ignored", {31'b0, seen}, 0);
    chk("rsv_size", {30'b0, lcu_size}, 0);
    // 64x64 LCUs, busy low, a stray start mid-stream.
    run_frame(2, 0, 16384, 5000, -1);
    // 16x16 LCUs over a ramp image, distinctive parameters on LCU 0.
    for (int i = 0; i < 16384; i++) img[i] = 8'(i);
    prm[0] = 24'hA5_1234;
    run_frame(0, 0, 16384, -1, -1);
    chk("lcu77_first", {24'b0, din_log[63 * 256]}, 32'h70);
    chk("p0_type", {30'b0, par_first[23:22]}, 2);
    chk("p0_band", {27'b0, par_first[21:17]}, 18);
    chk("p0_wo", {31'b0, par_first[16]}, 1);
    chk("p0_ofs", {16'b0, par_first[15:0]}, 32'h1234);
    for (int i = 0; i < 16384; i++) ref_log[i] = din_log[i];
    // Busy windows after every 16th transfer, plus an early finish that must be ignored.
    run_frame(0, 2, 16384, -1, 3000);
    mism = 0;
    for (int i = 0; i < 16384; i++) if (din_log[i] !== ref_log[i]) mism++;
    chk("busy_seq", mism, 0);
    // Random busy, reset in LCU 3 with a read in flight, then restart.
    for (int i = 0; i < 16384; i++) img[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) prm[i] = 24'($urandom);
    run_frame(1, 1, 3 * 1024 + 300, -1, -1);
    w = 0;
    #1;
    while (!img_rd && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("rd_issued", {31'b0, img_rd}, 1);
    @(posedge clk);
    #1 reset = 1;
    #1;
    chk("midrst_ctl", {img_rd, prm_rd, in_en, done, img_addr, prm_addr, lcu_x, lcu_y, lcu_size}, 0);
    chk("midrst_dat", {din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    run_frame(1, 1, 2048, -1, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
